// File: rtl/auto_player_driver_if.sv
// auto_player_driver_if: move-script push port and game-core player buses.
// master = the driver, slave = script source plus game core.
interface auto_player_driver_if;
  logic       move_valid;
  logic [2:0] move_data;
  logic       move_ready;
  logic [3:0] state_in;
  logic [2:0] player1;
  logic [2:0] player2;
  logic [2:0] player3;
  logic [2:0] player4;
  logic [2:0] player5;
  logic [2:0] player6;
  logic [5:0] player_clk;

  modport master (
    input  move_valid, move_data, state_in,
    output move_ready, player_clk,
    output player1, player2, player3,
    output player4, player5, player6
  );

  modport slave (
    output move_valid, move_data, state_in,
    input  move_ready, player_clk,
    input  player1, player2, player3,
    input  player4, player5, player6
  );
endinterface

// File: rtl/auto_player_driver.sv
// auto_player_driver: FIFO-scripted move initiator for the six-player core.
// Define AUTO_PLAYER_LFSR_EN to serve empty-FIFO turns from an LFSR.
module auto_player_driver #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SETUP_CYCLES   = 2,
  parameter int STROBE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  auto_player_driver_if.master bus,
  output logic                 busy,
  output logic                 game_over,
  output logic [2:0]           loser,
  output logic [7:0]           moves_issued,
  output logic                 err
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int M1   = (SETUP_CYCLES > STROBE_CYCLES) ?
                        SETUP_CYCLES : STROBE_CYCLES;
  localparam int MC   = (M1 > TIMEOUT_CYCLES) ? M1 : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MC + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_TURN, SETUP, STROBE, HOLD, DONE
  } state_t;

  state_t          state, state_d;
  logic [2:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic            empty, full, push, pop, take;
  logic [2:0]      head, mv;
  logic [CW-1:0]   cnt;
  logic [2:0]      turn;
  logic [3:0]      st_seen;
  logic [5:0][2:0] plr;
  logic [5:0]      strobe;
  logic            turn_ok, set_err, inc, go_set, go_clr;
`ifdef AUTO_PLAYER_LFSR_EN
  logic [7:0]      lfsr;
  logic            gen;
`endif

  assign empty = (count == '0);
  assign full  = (count == CNTW'(FIFO_DEPTH));
  assign head  = mem[rd_ptr];
  // A full FIFO still takes a push in the cycle it pops.
  assign bus.move_ready = !full || pop;
  assign push  = bus.move_valid && bus.move_ready;

  assign turn_ok = !bus.state_in[3] &&
                   (bus.state_in[2:0] != 3'd0) &&
                   (bus.state_in[2:0] != 3'd7);

`ifdef AUTO_PLAYER_LFSR_EN
  assign take = pop | gen;
  assign mv   = pop ? head : lfsr[2:0];
`else
  assign take = pop;
  assign mv   = head;
`endif

  assign busy = (state != IDLE) && (state != DONE);

  assign bus.player1    = plr[0];
  assign bus.player2    = plr[1];
  assign bus.player3    = plr[2];
  assign bus.player4    = plr[3];
  assign bus.player5    = plr[4];
  assign bus.player6    = plr[5];
  assign bus.player_clk = strobe;

  // Next-state and control decode
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    set_err = 1'b0;
    inc     = 1'b0;
    go_set  = 1'b0;
    go_clr  = 1'b0;
`ifdef AUTO_PLAYER_LFSR_EN
    gen     = 1'b0;
`endif
    unique case (state)
      IDLE: if (start) state_d = WAIT_TURN;
      WAIT_TURN: begin
        unique case (1'b1)
          bus.state_in[3]: begin
            go_set  = 1'b1;
            state_d = DONE;
          end
          turn_ok && !empty: begin
            pop     = 1'b1;
            state_d = SETUP;
          end
`ifdef AUTO_PLAYER_LFSR_EN
          turn_ok && empty: begin
            gen     = 1'b1;
            state_d = SETUP;
          end
`else
          turn_ok && empty: set_err = 1'b1;
`endif
          default: set_err = 1'b1;
        endcase
      end
      SETUP:
        if (cnt == CW'(SETUP_CYCLES - 1)) state_d = STROBE;
      STROBE:
        if (cnt == CW'(STROBE_CYCLES - 1)) state_d = HOLD;
      HOLD: begin
        unique case (1'b1)
          bus.state_in != st_seen: begin
            inc     = 1'b1;
            state_d = WAIT_TURN;
          end
          (bus.state_in == st_seen) &&
          (cnt == CW'(TIMEOUT_CYCLES - 1)): begin
            set_err = 1'b1;
            state_d = WAIT_TURN;
          end
          default: ;
        endcase
      end
      DONE: begin
        if (start) begin
          go_clr  = 1'b1;
          state_d = WAIT_TURN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; cnt restarts on every state change
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= (state_d != state) ? '0 : cnt + CW'(1);
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: ;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.move_data;
  end

  // Latch the move onto the active player's bus
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      plr     <= '0;
      turn    <= '0;
      st_seen <= '0;
    end else if (take) begin
      plr[bus.state_in[2:0] - 3'd1] <= mv;
      turn    <= bus.state_in[2:0];
      st_seen <= bus.state_in;
    end
  end

  // Registered one-hot strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      strobe <= '0;
    else if (state_d == STROBE)
      strobe <= 6'b1 << (turn - 3'd1);
    else
      strobe <= '0;
  end

  // Status: move counter, sticky error, game-over capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      moves_issued <= '0;
      err          <= 1'b0;
      game_over    <= 1'b0;
      loser        <= '0;
    end else begin
      if (inc && moves_issued != 8'hFF)
        moves_issued <= moves_issued + 8'd1;
      if (set_err) err <= 1'b1;
      if (go_set) begin
        game_over <= 1'b1;
        loser     <= bus.state_in[2:0];
      end else if (go_clr) begin
        game_over <= 1'b0;
        loser     <= '0;
      end
    end
  end

`ifdef AUTO_PLAYER_LFSR_EN
  // Fallback move generator, one step per move supplied
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      lfsr <= 8'hA5;
    else if (gen)
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
`endif

endmodule

// File: tb/tb_auto_player_driver.sv
// tb_auto_player_driver: directed sequence with random moves,
// checked against a queue-based model of the move script.
module tb_auto_player_driver;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       busy, game_over, err;
  logic [2:0] loser;
  logic [7:0] moves_issued;

  int vectors = 0;
  int miscompares = 0;

  logic [2:0] q[$];
  logic [2:0] pl [1:6];
  int         moves_m;
  bit         err_m;
  logic [7:0] lfsr_m;

  auto_player_driver_if bus();

  auto_player_driver #(
    .FIFO_DEPTH(8), .SETUP_CYCLES(2),
    .STROBE_CYCLES(1), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .bus(bus), .busy(busy), .game_over(game_over),
    .loser(loser), .moves_issued(moves_issued), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s miscompare", tag);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [17:0] players_dut();
    return {bus.player6, bus.player5, bus.player4,
            bus.player3, bus.player2, bus.player1};
  endfunction

  function automatic logic [17:0] pl_exp();
    return {pl[6], pl[5], pl[4], pl[3], pl[2], pl[1]};
  endfunction

  function automatic void model_reset();
    q.delete();
    for (int i = 1; i <= 6; i++) pl[i] = 3'd0;
    moves_m = 0;
    err_m   = 1'b0;
    lfsr_m  = 8'hA5;
  endfunction

  function automatic logic [2:0] take_move();
    logic [2:0] v;
    v = 3'd0;
    if (q.size() > 0) v = q.pop_front();
`ifdef AUTO_PLAYER_LFSR_EN
    else begin
      v = lfsr_m[2:0];
      lfsr_m = {lfsr_m[6:0],
                lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end
`endif
    return v;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    start = 1'b0;
    bus.move_valid = 1'b0;
    model_reset();
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic push_one(input logic [2:0] d);
    bus.move_valid = 1'b1;
    bus.move_data = d;
    chk("push_ready", bus.move_ready, 32'(q.size() < 8));
    if (q.size() < 8) q.push_back(d);
    tick(1);
    bus.move_valid = 1'b0;
  endtask

  task automatic arm(input int st);
    bus.state_in = 4'(st);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // mode 0: core advances; 1: core stalls; 2: reset during strobe
  task automatic do_move(input int t, input int nxt, input int mode,
                         input bit refill, input bit dual);
    logic [2:0] d;
    bus.state_in = 4'(t);
    d = 3'($urandom);
    if (dual) begin
      bus.move_valid = 1'b1;
      bus.move_data = d;
      chk("ready_on_pop", bus.move_ready, 1);
    end
    pl[t] = take_move();
    if (dual) q.push_back(d);
    tick(1);
    bus.move_valid = 1'b0;
    if (dual) chk("ready_full", bus.move_ready, 32'(q.size() < 8));
    chk("players", players_dut(), pl_exp());
    chk("strobe_setup1", bus.player_clk, 0);
    if (refill) begin
      d = 3'($urandom);
      bus.move_valid = 1'b1;
      bus.move_data = d;
      chk("ready_refill", bus.move_ready, 32'(q.size() < 8));
      if (q.size() < 8) q.push_back(d);
    end
    tick(1);
    bus.move_valid = 1'b0;
    chk("strobe_setup2", bus.player_clk, 0);
    tick(1);
    chk("strobe_on", bus.player_clk, 1 << (t - 1));
    if (mode == 2) begin
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      chk("strobe_reset", bus.player_clk, 0);
      chk("busy_reset", busy, 0);
      chk("players_reset", players_dut(), pl_exp());
      return;
    end
    tick(1);
    chk("strobe_off", bus.player_clk, 0);
    if (mode == 0) begin
      bus.state_in = 4'(nxt);
      tick(1);
      if (moves_m < 255) moves_m++;
      chk("moves", moves_issued, moves_m);
    end else begin
      tick(15);
      chk("err_pre_timeout", err, err_m);
      tick(1);
      err_m = 1'b1;
      chk("err_timeout", err, err_m);
      chk("moves_timeout", moves_issued, moves_m);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur, nxt;
    reset_n = 1'b0;
    start = 1'b0;
    bus.move_valid = 1'b0;
    bus.move_data = 3'd0;
    bus.state_in = 4'd0;
    model_reset();
    tick(2);
    reset_n = 1'b1;
    tick(1);
    chk("rst_players", players_dut(), pl_exp());
    chk("rst_strobe", bus.player_clk, 0);
    chk("rst_ready", bus.move_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_loser", loser, 0);
    chk("rst_moves", moves_issued, moves_m);
    chk("rst_err", err, err_m);

    // Fill past capacity, then play with a push during a full pop
    push_one(3'd1);
    for (int i = 1; i < 9; i++) push_one(3'($urandom));
    chk("full_ready", bus.move_ready, 32'(q.size() < 8));
    arm(1);
    chk("busy_armed", busy, 1);
    do_move(1, 5, 0, 1'b0, 1'b1);
    cur = 5;
    for (int k = 0; k < 3; k++) begin
      do nxt = $urandom_range(1, 6); while (nxt == cur);
      do_move(cur, nxt, 0, 1'b0, 1'b0);
      cur = nxt;
    end
    do_move(cur, cur, 1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      do nxt = $urandom_range(1, 6); while (nxt == cur);
      do_move(cur, nxt, 0, 1'b0, 1'b0);
      cur = nxt;
    end
    do_move(cur, cur, 2, 1'b0, 1'b0);
    tick(1);
    reset_n = 1'b1;

    // Empty-FIFO turn
`ifdef AUTO_PLAYER_LFSR_EN
    arm(2);
    do_move(2, 4, 0, 1'b0, 1'b0);
    chk("lfsr_no_err", err, err_m);
`else
    arm(3);
    chk("err_before_underrun", err, err_m);
    tick(1);
    err_m = 1'b1;
    chk("err_underrun", err, err_m);
    chk("no_strobe1", bus.player_clk, 0);
    bus.move_valid = 1'b1;
    bus.move_data = 3'd4;
    chk("ready_empty", bus.move_ready, 1);
    q.push_back(3'd4);
    tick(1);
    bus.move_valid = 1'b0;
    chk("no_strobe2", bus.player_clk, 0);
    do_move(3, 6, 0, 1'b0, 1'b0);
`endif

    // Game over, frozen outputs, restart
    bus.state_in = 4'hB;
    tick(1);
    chk("go_set", game_over, 1);
    chk("go_loser", loser, 3);
    chk("go_busy", busy, 0);
    bus.state_in = 4'd2;
    tick(2);
    chk("done_strobe", bus.player_clk, 0);
    chk("done_go", game_over, 1);
    chk("done_players", players_dut(), pl_exp());
    chk("done_moves", moves_issued, moves_m);
    arm(0);
    chk("restart_go", game_over, 0);
    chk("restart_loser", loser, 0);
    chk("restart_busy", busy, 1);
    tick(1);
    err_m = 1'b1;
    chk("err_invalid0", err, err_m);

    // Invalid state 7 from a clean reset
    do_reset();
    tick(1);
    chk("rst2_err", err, err_m);
    arm(7);
    chk("err_pre_invalid7", err, err_m);
    tick(1);
    err_m = 1'b1;
    chk("err_invalid7", err, err_m);

    // Long run through moves_issued saturation
    do_reset();
    tick(1);
    push_one(3'($urandom));
    arm(1);
    cur = 1;
    for (int k = 0; k < 258; k++) begin
      do nxt = $urandom_range(1, 6); while (nxt == cur);
      do_move(cur, nxt, 0, 1'b1, 1'b0);
      cur = nxt;
    end
    chk("moves_saturated", moves_issued, 255);
    chk("sat_err", err, err_m);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
